// File: rtl/reflet_ram_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the shared RAM macro.
// The arbiter connects through the slave modport; requesters and the RAM model connect through master.
interface reflet_ram_arbiter_if #(
  parameter int wordsize = 16
);
  logic                m0_req;
  logic                m0_we;
  logic [wordsize-1:0] m0_addr;
  logic [wordsize-1:0] m0_wdata;
  logic [wordsize-1:0] m0_rdata;
  logic                m0_ack;

  logic                m1_req;
  logic                m1_we;
  logic [wordsize-1:0] m1_addr;
  logic [wordsize-1:0] m1_wdata;
  logic [wordsize-1:0] m1_rdata;
  logic                m1_ack;

  logic [wordsize-1:0] ram_addr;
  logic [wordsize-1:0] ram_data_out;
  logic [wordsize-1:0] ram_data_in;
  logic                ram_we;
  logic                busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_data_in,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output ram_addr, ram_data_out, ram_we, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_data_in,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  ram_addr, ram_data_out, ram_we, busy
  );
endinterface

// File: rtl/reflet_ram_arbiter.sv
// Two-master arbiter for one single-port RAM with a fixed access window per grant.
// Define REFLET_ARBITER_RR_EN for round-robin ties; default is fixed priority to master 0.
module reflet_ram_arbiter #(
  parameter int wordsize    = 16,
  parameter int ram_latency = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  reflet_ram_arbiter_if.slave bus,
  output logic [1:0]          dbg_state
);

  // Handshake: a master raises req with we/addr/wdata stable and holds it until its
  // one-cycle ack; it must drop req on the edge ending that ack cycle. req is only
  // sampled in IDLE, so requests arriving during a window simply wait.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(ram_latency);

  state_t              state;
  logic [3:0]          count;
  logic                grant;
  logic                is_write;
  logic                we_r;
  logic [wordsize-1:0] addr_r;
  logic [wordsize-1:0] wdata_r;
  logic [wordsize-1:0] rdata0;
  logic [wordsize-1:0] rdata1;
  logic                ack0;
  logic                ack1;
  logic                busy_r;

  logic                any_req;
  logic                win;
  logic                win_we;
  logic [wordsize-1:0] win_addr;
  logic [wordsize-1:0] win_wdata;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef REFLET_ARBITER_RR_EN
  logic last;

  // On a tie the master not granted last wins; a lone requester always wins.
  always_comb begin
    win = bus.m1_req;
    if (bus.m0_req && bus.m1_req) win = ~last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (enable && state == IDLE && any_req) begin
      last <= win;
    end
  end
`else
  always_comb begin
    win = ~bus.m0_req;
  end
`endif

  always_comb begin
    win_we    = win ? bus.m1_we    : bus.m0_we;
    win_addr  = win ? bus.m1_addr  : bus.m0_addr;
    win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      grant    <= 1'b0;
      is_write <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy_r   <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= win;
            is_write <= win_we;
            we_r     <= win_we;
            addr_r   <= win_addr;
            wdata_r  <= win_wdata;
            count    <= LAT;
            busy_r   <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // The write strobe covers only the first enabled cycle of the window.
          we_r  <= 1'b0;
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= ACK;
            if (!is_write) begin
              if (grant) rdata1 <= bus.ram_data_in;
              else       rdata0 <= bus.ram_data_in;
            end
            if (grant) ack1 <= 1'b1;
            else       ack0 <= 1'b1;
          end
        end
        ACK: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // While stalled the strobe is masked so the RAM never sees a repeated write.
  assign bus.ram_we       = we_r & enable;
  assign bus.ram_addr     = addr_r;
  assign bus.ram_data_out = wdata_r;
  assign bus.m0_rdata     = rdata0;
  assign bus.m1_rdata     = rdata1;
  assign bus.m0_ack       = ack0;
  assign bus.m1_ack       = ack1;
  assign bus.busy         = busy_r;
  assign dbg_state        = state;

endmodule

// File: doc/reflet_ram_arbiter.md
# reflet_ram_arbiter

Shares one single-port RAM between two bus masters: port 0 is the CPU memory unit and port 1 is a secondary requester such as DMA or a debug loader. Each master uses a req/ack handshake. The arbiter grants one master at a time, drives the RAM address, write-data and write-enable lines for a fixed access window, captures read data, and acknowledges the granted master. It sits between the masters and the RAM macro in the top-level SoC.

## Interface
Parameters:
- wordsize, 16, width of addresses and data words.
- ram_latency, 2, cycles the RAM needs from address valid to read data valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  high = arbiter advances; low = all state frozen.
- m0_req, m1_req  input  1 each  access request; held high until the matching ack.
- m0_we, m1_we  input  1 each  1 = write, 0 = read; stable while req is high.
- m0_addr, m1_addr  input  wordsize each  access address.
- m0_wdata, m1_wdata  input  wordsize each  write data.
- m0_rdata, m1_rdata  output  wordsize each  registered read data for that master.
- m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
- ram_addr  output  wordsize  RAM address.
- ram_data_out  output  wordsize  RAM write data.
- ram_data_in  input  wordsize  RAM read data.
- ram_we  output  1  RAM write strobe.
- busy  output  1  high while the FSM is not in IDLE.

## Operation
FSM has three states: IDLE, ACCESS, ACK.

**IDLE**
- At a rising edge where enable=1 and at least one req=1, select a winner and latch its we, addr and wdata into the ram_* registers.
- Load the cycle counter with ram_latency and go to ACCESS.
- The grant register records the winner.

**ACCESS**
- The counter decrements once per enabled cycle.
- ram_we is high only in the first ACCESS cycle, and only for writes; it is 0 for the remaining cycles.
- ram_addr and ram_data_out are held for the whole window.
- When the counter equals 1, the edge that leaves ACCESS does two things:
  - For reads, it loads ram_data_in into the granted master's rdata.
  - It moves the FSM to ACK.

**ACK**
- The granted master's ack is 1 for exactly this cycle.
- The next enabled edge returns the FSM to IDLE.
- Arbitration is not performed in ACK.

**Other rules**
- rdata of each master changes only on completion of a read granted to that master. It is held otherwise, including across writes and across the other master's accesses.
- Masters must drop req on the edge that ends their ack cycle. If req is still high in the following IDLE cycle, it is a new request.
- A req that drops before its ack is a protocol violation. The access in flight still completes and the ack is still issued.
- Address and data pass through unchanged. No wrap-around or width conversion is performed.

## Timing
- Request sampled high at edge E. ram_* outputs are valid from E+1.
- ack is high in cycle E+ram_latency+1. The arbiter is back in IDLE at E+ram_latency+2.
- Minimum spacing between accesses: ram_latency+2 cycles. With default ram_latency=2, one access every 4 cycles.
- Reset values, applied asynchronously while reset=0:
  - FSM = IDLE, counter = 0, grant = 0.
  - ram_addr, ram_data_out, ram_we = 0.
  - m0_rdata, m1_rdata = 0.
  - m0_ack, m1_ack, busy = 0.
  - Round-robin last-grant register = 1, so master 0 wins the first tie.
- Reset asserted mid-access: ram_we drops to 0 immediately. The access is abandoned with no ack issued, and the master must re-request.
- enable=0: state, counter and all outputs hold their values, except that ram_we is forced to 0. The write strobe is issued once enable returns, in the same ACCESS cycle it would otherwise have occupied.
- Requests from both masters at the same edge are resolved by the policy in Configuration. The loser keeps req high and is granted at its next IDLE edge.

## Configuration
- Macro `REFLET_ARBITER_RR_EN`.
- Defined: round-robin arbitration.
  - On a tie, the master not granted last wins.
  - last-grant updates on every grant.
  - Each master is guaranteed a grant within two access windows of raising req.
- Undefined: fixed priority, master 0 always wins ties.
  - The last-grant register is not implemented.
  - Master 1 can starve while m0_req stays high.

## Test plan
- **Single read:** reset, then m0 read addr 0x0010 with RAM returning 0xBEEF.
  - ram_addr=0x0010 from E+1.
  - m0_ack pulses at E+3, with m0_rdata=0xBEEF in that same cycle.
  - m1_rdata stays 0.
- **Single write:** m1 write addr 0x0020, data 0x1234.
  - ram_we is high for exactly one cycle (E+1), with ram_data_out=0x1234.
  - m1_ack pulses at E+3.
  - m1_rdata is unchanged.
- **Contention:** both masters request reads continuously.
  - With `REFLET_ARBITER_RR_EN`: grants alternate 0,1,0,1, each ack 4 cycles apart.
  - Without it: only m0 is acked while m0_req stays high.
- **Enable stall:** drop enable for 3 cycles during ACCESS of a write.
  - ram_we is 0 while enable is low.
  - ack is delayed by exactly 3 cycles.
  - ram_addr is held throughout.
- **Reset mid-access:** assert reset during ACCESS of an m0 write.
  - ram_we, busy and ack go to 0 with no clock edge.
  - After release, a fresh m0 request completes normally.
- **Latency parameter:** ram_latency=1 and ram_latency=5.
  - ack arrives at E+2 and E+6 respectively.
  - busy is high for ram_latency+1 cycles.
